// File: rtl/lfsr_index_decoder_if.sv
// rtl/lfsr_index_decoder_if.sv - command/result bundle of the LFSR index decoder
// LFSR_INDEX_DECODER_TIMEOUT_EN adds the max_steps field.
interface lfsr_index_decoder_if #(
    parameter int N         = 64,
    parameter int N_counter = 32
);
    logic                 start;
    logic                 abort;
    logic [N-1:0]         seed;
    logic [N-1:0]         polynomial;
    logic [N-1:0]         target;
`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
    logic [N_counter-1:0] max_steps;
`endif
    logic                 busy;
    logic                 done;
    logic                 found;
    logic [N_counter-1:0] index;

    modport master (
        output start, abort, seed, polynomial, target,
`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
        output max_steps,
`endif
        input  busy, done, found, index
    );

    modport slave (
        input  start, abort, seed, polynomial, target,
`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
        input  max_steps,
`endif
        output busy, done, found, index
    );
endinterface

// File: rtl/lfsr_index_decoder.sv
// rtl/lfsr_index_decoder.sv - replays the Galois LFSR generator to find the step index of a target value
// LFSR_INDEX_DECODER_TIMEOUT_EN enables an optional step limit (max_steps).
module lfsr_index_decoder #(
    parameter int N         = 64,
    parameter int N_counter = 32
) (
    input  logic                clk,
    input  logic                rst,
    lfsr_index_decoder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

    state_t               r_state;
    logic [N-1:0]         r_lfsr;
    logic [N-2:0]         r_poly;
    logic [N-1:0]         r_target;
    logic [N_counter-1:0] r_counter;
    logic                 r_found;
    logic [N_counter-1:0] r_index;
`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
    logic [N_counter-1:0] r_max_steps;
`endif

    state_t               w_next_state;
    logic                 w_load;
    logic                 w_clear;
    logic                 w_finish;
    logic                 w_hit;
    logic                 w_step;
    logic                 w_match;
    logic                 w_limit;
    logic [N-1:0]         w_lfsr_step;
    logic                 w_unused_poly_msb;

    // The generator never uses the top tap: bit N-1 always receives the feedback bit.
    assign w_unused_poly_msb = bus.polynomial[N-1];

    assign w_match = (r_lfsr == r_target);
`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
    assign w_limit = (r_counter == {N_counter{1'b1}}) || (r_counter == r_max_steps);
`else
    assign w_limit = (r_counter == {N_counter{1'b1}});
`endif

    always_comb begin
        w_lfsr_step = '0;
        for (int i = 0; i < N - 1; i++) begin
            w_lfsr_step[i] = r_poly[i] ? (r_lfsr[i+1] ^ r_lfsr[0]) : r_lfsr[i+1];
        end
        w_lfsr_step[N-1] = r_lfsr[0];
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_finish     = 1'b0;
        w_hit        = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.abort) begin
                    w_clear      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (bus.abort) begin
                    w_clear      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_match) begin
                    w_finish     = 1'b1;
                    w_hit        = 1'b1;
                    w_next_state = S_DONE;
                end else if (w_limit) begin
                    w_finish     = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr      <= '0;
            r_poly      <= '0;
            r_target    <= '0;
            r_counter   <= '0;
            r_found     <= 1'b0;
            r_index     <= '0;
`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
            r_max_steps <= '0;
`endif
        end else begin
            if (w_load) begin
                r_lfsr      <= bus.seed;
                r_poly      <= bus.polynomial[N-2:0];
                r_target    <= bus.target;
                r_counter   <= '0;
                r_found     <= 1'b0;
                r_index     <= '0;
`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
                r_max_steps <= bus.max_steps;
`endif
            end else if (w_clear) begin
                r_found <= 1'b0;
                r_index <= '0;
            end else if (w_finish) begin
                r_found <= w_hit;
                r_index <= r_counter;
            end else if (w_step) begin
                r_lfsr    <= w_lfsr_step;
                r_counter <= r_counter + 1'b1;
            end
        end
    end

    assign bus.busy  = (r_state == S_SEARCH);
    assign bus.done  = (r_state == S_DONE);
    assign bus.found = r_found;
    assign bus.index = r_index;
endmodule

// File: tb/tb_lfsr_index_decoder.sv
// tb/tb_lfsr_index_decoder.sv - scoreboard bench for lfsr_index_decoder (N=4, N_counter=4)
module tb_lfsr_index_decoder;
    typedef struct {
        logic       found;
        logic [3:0] index;
        int         latency;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    lfsr_index_decoder_if #(.N(4), .N_counter(4)) bus ();

    lfsr_index_decoder #(.N(4), .N_counter(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [3:0] ref_step(input logic [3:0] l, input logic [3:0] p);
        logic fb;
        fb = l[0];
        return {fb, l[3:1]} ^ (fb ? {1'b0, p[2:0]} : 4'b0000);
    endfunction

    function automatic exp_t ref_search(input logic [3:0] s, input logic [3:0] p,
                                        input logic [3:0] t, input logic [3:0] lim);
        exp_t       e;
        logic [3:0] l;
        l = s;
        e.found = 1'b0;
        e.index = 4'hF;
        e.latency = 16;
        for (int c = 0; c < 16; c++) begin
            if (l == t) begin
                e.found = 1'b1; e.index = 4'(c); e.latency = c + 1;
                return e;
            end
            if (c == int'(lim) || c == 15) begin
                e.found = 1'b0; e.index = 4'(c); e.latency = c + 1;
                return e;
            end
            l = ref_step(l, p);
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic f, input logic [3:0] i, input int lat);
        exp_t e;
        e.found = f; e.index = i; e.latency = lat;
        return e;
    endfunction

    task automatic run_search(input logic [3:0] s, input logic [3:0] p, input logic [3:0] t,
                              input logic [3:0] lim, input bit mid_start, input string name);
        exp_t e;
        int   cyc;
        int   busy_n;
        @(negedge clk);
        bus.seed = s; bus.polynomial = p; bus.target = t;
`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
        bus.max_steps = lim;
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.seed = ~s; bus.target = ~t;
        cyc = 0;
        busy_n = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy === 1'b1) busy_n++;
            bus.start = (mid_start && cyc == 1);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, bus.done, cyc);
        end
        total++;
        if (bus.found !== e.found) begin
            bad++; $display("FAIL %s found: got %b required %b", name, bus.found, e.found);
        end
        total++;
        if (bus.index !== e.index) begin
            bad++; $display("FAIL %s index: got %h required %h", name, bus.index, e.index);
        end
        total++;
        if (cyc != e.latency) begin
            bad++; $display("FAIL %s latency: got %0d required %0d", name, cyc, e.latency);
        end
        total++;
        if (busy_n != e.latency) begin
            bad++; $display("FAIL %s busy cycles: got %0d required %0d", name, busy_n, e.latency);
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.found, bus.index} !== 7'b0) begin
            bad++; $display("FAIL reset outputs: got %b required 0000000", {bus.busy, bus.done, bus.found, bus.index});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_found;
        sb.push_back(mk(1'b1, 4'd3, 4));
        run_search(4'b0001, 4'b0100, 4'b0011, 4'hF, 1'b0, "idx3");
        sb.push_back(mk(1'b1, 4'd0, 1));
        run_search(4'b0001, 4'b0100, 4'b0001, 4'hF, 1'b0, "idx0");
    endtask

    task automatic test_not_found;
        sb.push_back(mk(1'b0, 4'hF, 16));
        run_search(4'b0001, 4'b0100, 4'b0000, 4'hF, 1'b1, "zero_target");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({bus.done, bus.found, bus.index} !== {1'b1, 1'b0, 4'hF}) begin
                bad++; $display("FAIL done_hold: got %b required 1 0 1111", {bus.done, bus.found, bus.index});
            end
        end
        sb.push_back(mk(1'b1, 4'd1, 2));
        run_search(4'b0001, 4'b0100, 4'b1100, 4'hF, 1'b0, "restart_from_done");
    endtask

    task automatic test_abort;
        @(negedge clk);
        bus.seed = 4'b0001; bus.polynomial = 4'b0100; bus.target = 4'b0000;
`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
        bus.max_steps = 4'hF;
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        total++;
        if ({bus.busy, bus.done, bus.found, bus.index} !== 7'b0) begin
            bad++; $display("FAIL abort_search: got %b required 0000000", {bus.busy, bus.done, bus.found, bus.index});
        end
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        total++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            bad++; $display("FAIL start_abort_idle: busy/done got %b required 00", {bus.busy, bus.done});
        end
        sb.push_back(mk(1'b1, 4'd2, 3));
        run_search(4'b0001, 4'b0100, 4'b0110, 4'hF, 1'b0, "before_done_abort");
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        total++;
        if ({bus.busy, bus.done, bus.found, bus.index} !== 7'b0) begin
            bad++; $display("FAIL abort_done: got %b required 0000000", {bus.busy, bus.done, bus.found, bus.index});
        end
    endtask

    task automatic test_rst_mid;
        @(negedge clk);
        bus.seed = 4'b0001; bus.polynomial = 4'b0100; bus.target = 4'b0000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.found, bus.index} !== 7'b0) begin
            bad++; $display("FAIL async_rst: got %b required 0000000", {bus.busy, bus.done, bus.found, bus.index});
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(mk(1'b1, 4'd3, 4));
        run_search(4'b0001, 4'b0100, 4'b0011, 4'hF, 1'b0, "after_rst");
    endtask

    task automatic test_random;
        logic [3:0] s;
        logic [3:0] p;
        logic [3:0] t;
        int         k;
        for (int n = 0; n < 8; n++) begin
            s = 4'($urandom_range(1, 15));
            p = 4'($urandom_range(0, 15));
            k = int'($urandom_range(0, 12));
            t = s;
            for (int j = 0; j < k; j++) t = ref_step(t, p);
            sb.push_back(ref_search(s, p, t, 4'hF));
            run_search(s, p, t, 4'hF, 1'b0, "random");
        end
    endtask

`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
    task automatic test_timeout;
        sb.push_back(mk(1'b0, 4'd2, 3));
        run_search(4'b0001, 4'b0100, 4'b0011, 4'd2, 1'b0, "timeout2");
        sb.push_back(mk(1'b1, 4'd1, 2));
        run_search(4'b0001, 4'b0100, 4'b1100, 4'd2, 1'b0, "timeout_restart");
        sb.push_back(mk(1'b0, 4'd0, 1));
        run_search(4'b0001, 4'b0100, 4'b0011, 4'd0, 1'b0, "timeout0");
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.seed = '0; bus.polynomial = '0; bus.target = '0;
`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
        bus.max_steps = 4'hF;
`endif
        test_reset();
        test_found();
        test_not_found();
        test_back_to_back();
        test_abort();
        test_rst_mid();
        test_random();
`ifdef LFSR_INDEX_DECODER_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
